// File: rtl/store_pkg.sv
// Shared encodings for the narrow store path: access sizes, FSM states, lane geometry
// and the alignment rule used to reject bad requests.
package store_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_ILL  = 2'b11;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_MERGE = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_ERR   = 3'd4;

  localparam int LANES  = 4;
  localparam int LANE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = S_IDLE,
    ST_READ  = S_READ,
    ST_MERGE = S_MERGE,
    ST_WRITE = S_WRITE,
    ST_ERR   = S_ERR
  } state_t;

  // Illegal size, odd halfword, or word not on a 4-byte boundary.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    case (size)
      SIZE_BYTE: bad = 1'b0;
      SIZE_HALF: bad = addr_lo[0];
      SIZE_WORD: bad = (addr_lo != 2'b00);
      default:   bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/byte_lane_merge.sv
// Combinational lane replacement: overlays the narrowed store data onto the word read
// back from memory, leaving untouched lanes at their old value.
module byte_lane_merge
  import store_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] new_data,
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  output logic [31:0] merged
);

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic       sel;
      logic [7:0] src;

      always_comb begin
        sel = 1'b0;
        src = new_data[LANE_W*gi +: LANE_W];
        case (size)
          SIZE_BYTE: begin
            sel = (addr_lo == 2'(gi));
            src = new_data[7:0];
          end
          SIZE_HALF: begin
            // Half data always comes from bits [15:0]; lane parity picks the byte.
            sel = (addr_lo[1] == 1'(gi / 2));
            src = new_data[LANE_W*(gi % 2) +: LANE_W];
          end
          SIZE_WORD: begin
            sel = 1'b1;
            src = new_data[LANE_W*gi +: LANE_W];
          end
          default: begin
            sel = 1'b0;
            src = new_data[LANE_W*gi +: LANE_W];
          end
        endcase
      end

      assign merged[LANE_W*gi +: LANE_W] = sel ? src : old_word[LANE_W*gi +: LANE_W];
    end
  endgenerate

endmodule

// File: rtl/store_narrow_rmw.sv
// MEM-stage store unit: word stores go straight to memory, byte/half stores do a
// read-modify-write, and misaligned or illegal requests are dropped with a pulse.
module store_narrow_rmw
  import store_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  input  logic [1:0]        req_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              mem_wr_en,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic              busy,
  output logic              done,
  output logic              misaligned
);

  state_t            state_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] data_reg;
  logic [1:0]        size_reg;

  logic [ADDR_W-1:0] mem_addr_reg;
  logic              mem_rd_en_reg;
  logic              mem_wr_en_reg;
  logic [DATA_W-1:0] mem_wr_data_reg;
  logic              done_reg;
  logic              misaligned_reg;

  logic [DATA_W-1:0] merged_word;
  logic [ADDR_W-1:0] req_word_addr;
  logic [ADDR_W-1:0] cap_word_addr;

  assign req_word_addr = {req_addr[ADDR_W-1:2], 2'b00};
  assign cap_word_addr = {addr_reg[ADDR_W-1:2], 2'b00};

  byte_lane_merge u_merge (
    .old_word (mem_rd_data),
    .new_data (data_reg),
    .size     (size_reg),
    .addr_lo  (addr_reg[1:0]),
    .merged   (merged_word)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg       <= ST_IDLE;
      addr_reg        <= '0;
      data_reg        <= '0;
      size_reg        <= '0;
      mem_addr_reg    <= '0;
      mem_rd_en_reg   <= 1'b0;
      mem_wr_en_reg   <= 1'b0;
      mem_wr_data_reg <= '0;
      done_reg        <= 1'b0;
      misaligned_reg  <= 1'b0;
    end else begin
      // Strobes and their payload are single-cycle; default everything back to idle.
      mem_addr_reg    <= '0;
      mem_rd_en_reg   <= 1'b0;
      mem_wr_en_reg   <= 1'b0;
      mem_wr_data_reg <= '0;
      done_reg        <= 1'b0;
      misaligned_reg  <= 1'b0;

      case (state_reg)
        ST_IDLE: begin
          if (req_valid) begin
            addr_reg <= req_addr;
            data_reg <= req_data;
            size_reg <= req_size;
            if (is_misaligned(req_size, req_addr[1:0])) begin
              state_reg      <= ST_ERR;
              misaligned_reg <= 1'b1;
            end else if (req_size == SIZE_WORD) begin
              state_reg       <= ST_WRITE;
              mem_wr_en_reg   <= 1'b1;
              done_reg        <= 1'b1;
              mem_addr_reg    <= req_word_addr;
              mem_wr_data_reg <= req_data;
            end else begin
              state_reg     <= ST_READ;
              mem_rd_en_reg <= 1'b1;
              mem_addr_reg  <= req_word_addr;
            end
          end
        end
        ST_READ: begin
          state_reg <= ST_MERGE;
        end
        ST_MERGE: begin
          // Read data is valid this cycle; the merged word is captured as write payload.
          state_reg       <= ST_WRITE;
          mem_wr_en_reg   <= 1'b1;
          done_reg        <= 1'b1;
          mem_addr_reg    <= cap_word_addr;
          mem_wr_data_reg <= merged_word;
        end
        ST_WRITE: state_reg <= ST_IDLE;
        ST_ERR:   state_reg <= ST_IDLE;
        default:  state_reg <= ST_IDLE;
      endcase
    end
  end

  assign req_ready   = (state_reg == ST_IDLE) && !Reset;
  assign busy        = (state_reg != ST_IDLE);
  assign mem_addr    = mem_addr_reg;
  assign mem_rd_en   = mem_rd_en_reg;
  assign mem_wr_en   = mem_wr_en_reg;
  assign mem_wr_data = mem_wr_data_reg;
  assign done        = done_reg;
  assign misaligned  = misaligned_reg;

endmodule
